// File: rtl/lampFPU_pkg.sv
// Shared definitions for the lampFPU square-root datapath.
//   LAMP_FLOAT_F_DW : fraction width of the float format (7)
//   SW / RW / XW    : significand, result and radicand widths
//   sqrt_state_t    : iterative square-root FSM encoding
//   sqrt_step_t     : remainder/root pair produced by one iteration
package lampFPU_pkg;

  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int SW              = 1 + LAMP_FLOAT_F_DW;  // significand incl. hidden bit
  localparam int RW              = 2 * SW;               // root width (1.15 fixed point)
  localparam int XW              = 4 * SW;               // radicand width
  // The remainder never exceeds 2*root; two extra guard bits absorb the
  // left shift that brings in the next radicand bit pair.
  localparam int REM_W           = RW + 4;
  localparam int CNT_W           = 5;

  // Radicand alignment: the odd-exponent case doubles the significand.
  localparam int SHIFT_ODD       = 2 * SW + LAMP_FLOAT_F_DW + 1;  // 24
  localparam int SHIFT_EVEN      = 2 * SW + LAMP_FLOAT_F_DW;      // 23

  localparam logic [CNT_W-1:0] SQRT_ITERS = CNT_W'(RW);
  localparam logic [CNT_W-1:0] LAST_ITER  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

  typedef struct packed {
    logic [REM_W-1:0] rem;
    logic [RW-1:0]    root;
  } sqrt_step_t;

endpackage

// File: rtl/square_root_module.sv
// Iterative significand square root for the lampFPU.
// Restoring digit-by-digit integer square root of the aligned radicand,
// one result bit per clock, MSB first, 16 iterations.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   doSqrt_i     : start request, sampled only while idle
//   s_i          : unsigned significand with hidden bit (1.7 fixed point)
//   is_exp_odd_i : biased exponent is odd -> radicand is doubled
//   res_o        : floor(sqrt(radicand)), 1.15 fixed point, held until next result
//   valid_o      : one-cycle pulse while res_o carries a fresh result
module square_root_module
  import lampFPU_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          doSqrt_i,
  input  logic [SW-1:0] s_i,
  input  logic          is_exp_odd_i,
  output logic [RW-1:0] res_o,
  output logic          valid_o
);

  sqrt_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XW-1:0]    x_q;     // captured radicand, consumed two bits per iteration
  logic [REM_W-1:0] rem_q;
  logic [RW-1:0]    root_q;
  sqrt_step_t       step;

  function automatic logic [XW-1:0] load_radicand(input logic [SW-1:0] s,
                                                   input logic odd);
    logic [XW-1:0] x;
    x = {{(XW-SW){1'b0}}, s};
    return odd ? (x << SHIFT_ODD) : (x << SHIFT_EVEN);
  endfunction

  // One restoring iteration: bring in the next bit pair, try subtracting
  // 4*root+1, keep the subtraction and emit a 1 only if it does not underflow.
  function automatic sqrt_step_t sqrt_step(input logic [REM_W-1:0] rem,
                                           input logic [RW-1:0]    root,
                                           input logic [1:0]       pair);
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;
    sqrt_step_t       r;
    rem_sh = {rem[REM_W-3:0], pair};
    trial  = {{(REM_W-RW-2){1'b0}}, root, 2'b01};
    if (rem_sh >= trial) begin
      r.rem  = rem_sh - trial;
      r.root = {root[RW-2:0], 1'b1};
    end else begin
      r.rem  = rem_sh;
      r.root = {root[RW-2:0], 1'b0};
    end
    return r;
  endfunction

  assign step = sqrt_step(rem_q, root_q, x_q[XW-1 -: 2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (doSqrt_i) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_ITER) state_d = DONE;
      DONE:    state_d = IDLE;  // a lingering start request is ignored here
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      res_o  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (doSqrt_i) begin
            x_q    <= load_radicand(s_i, is_exp_odd_i);
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= SQRT_ITERS;
          end
        end
        BUSY: begin
          rem_q  <= step.rem;
          root_q <= step.root;
          x_q    <= x_q << 2;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == LAST_ITER) res_o <= step.root;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_square_root_module.sv
// Directed and table-driven bench for square_root_module.
module tb_square_root_module;
  import lampFPU_pkg::*;

  logic          clk_tb = 1'b0;
  logic          rst;
  logic          doSqrt_i;
  logic [SW-1:0] s_i;
  logic          is_exp_odd_i;
  logic [RW-1:0] res_o;
  logic          valid_o;

  int total = 0;
  int bad   = 0;

  square_root_module dut (
    .clk          (clk_tb),
    .rst          (rst),
    .doSqrt_i     (doSqrt_i),
    .s_i          (s_i),
    .is_exp_odd_i (is_exp_odd_i),
    .res_o        (res_o),
    .valid_o      (valid_o)
  );

  always #5 clk_tb = ~clk_tb;

  typedef struct {
    logic [7:0]  s;
    logic        odd;
    logic [15:0] res;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: binary search for the largest r with r*r <= x.
  function automatic logic [15:0] ref_sqrt(input logic [7:0] s, input logic odd);
    longint unsigned x, lo, hi, mid;
    x  = odd ? (longint'(s) << 24) : (longint'(s) << 23);
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else                hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // Called #1 after an edge with the DUT idle. Scrambles the inputs during
  // the operation to confirm only the captured copies are used.
  task automatic run_op(input logic [7:0] s, input logic odd,
                        input logic [15:0] exp, input string name);
    int cyc;
    doSqrt_i     = 1'b1;
    s_i          = s;
    is_exp_odd_i = odd;
    @(posedge clk_tb); #1;
    doSqrt_i     = 1'b0;
    s_i          = ~s;
    is_exp_odd_i = ~odd;
    cyc = 0;
    while (valid_o !== 1'b1 && cyc < 20) begin
      @(posedge clk_tb); #1;
      cyc++;
      if (cyc == 4) doSqrt_i = 1'b1;
      if (cyc == 8) doSqrt_i = 1'b0;
    end
    check({name, " latency"}, cyc, 16);
    check({name, " res"}, res_o, exp);
    @(posedge clk_tb); #1;
    check({name, " pulse_end"}, valid_o, 1'b0);
    check({name, " hold"}, res_o, exp);
  endtask

  initial begin
    vecs[0]  = '{8'hC8, 1'b0, 16'hA000};
    vecs[1]  = '{8'hC8, 1'b1, 16'hE246};
    vecs[2]  = '{8'h80, 1'b0, 16'h8000};
    vecs[3]  = '{8'h80, 1'b1, 16'hB504};
    vecs[4]  = '{8'hFF, 1'b1, 16'hFF7F};
    vecs[5]  = '{8'hFF, 1'b0, 16'hB4AA};
    vecs[6]  = '{8'h00, 1'b0, 16'h0000};
    vecs[7]  = '{8'h01, 1'b0, 16'h0B50};
    vecs[8]  = '{8'h01, 1'b1, 16'h1000};
    vecs[9]  = '{8'hC0, 1'b0, 16'h9CC4};
    vecs[10] = '{8'hC0, 1'b1, 16'hDDB3};

    rst          = 1'b1;
    doSqrt_i     = 1'b0;
    s_i          = '0;
    is_exp_odd_i = 1'b0;
    repeat (3) @(posedge clk_tb);
    #1;
    check("reset valid", valid_o, 1'b0);
    check("reset res", res_o, 16'h0000);
    rst = 1'b0;
    @(posedge clk_tb); #1;
    check("idle valid", valid_o, 1'b0);

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].s, vecs[i].odd, vecs[i].res, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      logic [7:0] rs;
      logic       ro;
      rs = 8'($urandom_range(128, 255));
      ro = 1'($urandom_range(0, 1));
      run_op(rs, ro, ref_sqrt(rs, ro), $sformatf("rnd%0d", i));
    end

    // Abort mid-operation: res_o currently holds a nonzero result.
    begin
      int seen;
      doSqrt_i     = 1'b1;
      s_i          = 8'hC8;
      is_exp_odd_i = 1'b0;
      @(posedge clk_tb); #1;
      doSqrt_i = 1'b0;
      repeat (8) @(posedge clk_tb);
      #1;
      rst = 1'b1;
      #1;
      check("async rst valid", valid_o, 1'b0);
      check("async rst res", res_o, 16'h0000);
      repeat (2) @(posedge clk_tb);
      #1;
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk_tb); #1;
        if (valid_o === 1'b1) seen++;
      end
      check("abort no pulse", seen, 0);
      check("abort res", res_o, 16'h0000);
      run_op(8'hC8, 1'b0, 16'hA000, "after_abort");
    end

    // Continuous start request: one result every 18 cycles, never back to back.
    begin
      int times[$];
      int prev_v;
      int overlap;
      prev_v  = 0;
      overlap = 0;
      doSqrt_i     = 1'b1;
      s_i          = 8'hC8;
      is_exp_odd_i = 1'b1;
      for (int t = 1; t <= 60; t++) begin
        @(posedge clk_tb); #1;
        if (valid_o === 1'b1) begin
          times.push_back(t);
          check("hold res", res_o, 16'hE246);
          if (prev_v != 0) overlap++;
          prev_v = 1;
        end else begin
          prev_v = 0;
        end
      end
      doSqrt_i = 1'b0;
      check("hold pulses", times.size(), 3);
      check("hold overlap", overlap, 0);
      if (times.size() >= 1) check("hold first", times[0], 17);
      for (int k = 1; k < times.size(); k++)
        check("hold period", times[k] - times[k-1], 18);
      repeat (20) @(posedge clk_tb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
